// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI SRAM responder (23A512/23LC512 subset) with READ 0x03 / WRITE 0x02.
// Defining `IDLI_SQI_MEM_MODE_EN adds the WRMR/RDMR mode register (byte/page/sequential).
module idli_sqi_mem_m #(
    parameter int ADDR_W = 16
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_INSTR, ST_ADDR, ST_DUMMY, ST_RD, ST_WR, ST_IGNORE, ST_WRMR, ST_RDMR
    } state_t;

    logic [7:0]        r_mem [2**ADDR_W];
    state_t            r_state;
    logic              r_sck_q;
    logic              r_armed;   // a reset leaves us deaf until CS has been seen high
    logic              r_wr;
    logic              r_lo;      // next RD/WR/RDMR nibble is the low one
    logic [1:0]        r_cnt;
    logic [11:0]       r_sh;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_out_q;
    logic [3:0]        r_hi;
    logic              r_oe;
    logic              w_rise;
    logic              w_we;
    logic [7:0]        w_instr;
    logic [15:0]       w_addr16;
    logic [ADDR_W-1:0] w_addr_nx;

    assign w_rise   = i_mem_sck & ~r_sck_q;
    assign w_instr  = {r_sh[3:0], i_mem_sio};
    assign w_addr16 = {r_sh[11:0], i_mem_sio};
    assign w_we     = i_mem_rst_n & ~i_mem_cs & w_rise & (r_state == ST_WR) & r_lo;

`ifdef IDLI_SQI_MEM_MODE_EN
    logic [7:0] r_mode;

    always_comb begin
        w_addr_nx = r_addr + ADDR_W'(1);
        if (r_mode[7:6] == 2'b00)
            w_addr_nx = r_addr;
        else if (r_mode[7:6] == 2'b10)
            w_addr_nx = {r_addr[ADDR_W-1:5], r_addr[4:0] + 5'd1};
    end
`else
    assign w_addr_nx = r_addr + ADDR_W'(1);
`endif

    always_ff @(posedge i_mem_gck) begin
        if (w_we)
            r_mem[r_addr] <= {r_hi, i_mem_sio};
    end

    always_ff @(posedge i_mem_gck) begin
        if (!i_mem_rst_n) begin
            r_state <= ST_IDLE;
            r_sck_q <= 1'b0;
            r_armed <= 1'b0;
            r_wr    <= 1'b0;
            r_lo    <= 1'b0;
            r_cnt   <= 2'd0;
            r_sh    <= 12'h0;
            r_addr  <= '0;
            r_out_q <= 4'h0;
            r_hi    <= 4'h0;
            r_oe    <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
            r_mode  <= 8'h40;
`endif
        end else begin
            r_sck_q <= i_mem_sck;
            if (i_mem_cs) begin
                r_state <= ST_IDLE;
                r_armed <= 1'b1;
                r_cnt   <= 2'd0;
                r_lo    <= 1'b0;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (r_armed) begin
                        r_state <= ST_INSTR;
                        if (w_rise) begin
                            r_sh  <= {r_sh[7:0], i_mem_sio};
                            r_cnt <= 2'd1;
                        end
                    end
                    ST_INSTR: if (w_rise) begin
                        r_sh  <= {r_sh[7:0], i_mem_sio};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_cnt <= 2'd0;
                            case (w_instr)
                                8'h03: begin r_state <= ST_ADDR; r_wr <= 1'b0; end
                                8'h02: begin r_state <= ST_ADDR; r_wr <= 1'b1; end
`ifdef IDLI_SQI_MEM_MODE_EN
                                8'h01: r_state <= ST_WRMR;
                                8'h05: begin
                                    r_state <= ST_RDMR;
                                    r_out_q <= r_mode[7:4];
                                    r_oe    <= 1'b1;
                                    r_lo    <= 1'b1;
                                end
`endif
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        r_sh  <= {r_sh[7:0], i_mem_sio};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_addr  <= w_addr16[ADDR_W-1:0];
                            r_state <= r_wr ? ST_WR : ST_DUMMY;
                            r_lo    <= 1'b0;
                        end
                    end
                    ST_DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_out_q <= r_mem[r_addr][7:4];
                            r_oe    <= 1'b1;
                            r_lo    <= 1'b1;
                            r_state <= ST_RD;
                        end
                    end
                    // out_q changes on the GCK that sees the SCK rise, so it holds through the next SCK high
                    ST_RD: if (w_rise) begin
                        r_lo <= ~r_lo;
                        if (r_lo) begin
                            r_out_q <= r_mem[r_addr][3:0];
                        end else begin
                            r_addr  <= w_addr_nx;
                            r_out_q <= r_mem[w_addr_nx][7:4];
                        end
                    end
                    ST_WR: if (w_rise) begin
                        r_lo <= ~r_lo;
                        if (r_lo)
                            r_addr <= w_addr_nx;
                        else
                            r_hi <= i_mem_sio;
                    end
`ifdef IDLI_SQI_MEM_MODE_EN
                    ST_WRMR: if (w_rise && r_cnt != 2'd2) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd0)
                            r_hi <= i_mem_sio;
                        else
                            r_mode <= {r_hi, i_mem_sio};
                    end
                    ST_RDMR: if (w_rise) begin
                        r_lo    <= ~r_lo;
                        r_out_q <= r_lo ? r_mode[3:0] : r_mode[7:4];
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_mem_sio    = r_oe ? r_out_q : 4'h0;
    assign o_mem_sio_oe = r_oe;
endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: directed SQI transactions plus random writes/reads checked
// against a byte-array model of the SRAM.
module tb_idli_sqi_mem_m;
    logic       gck = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] sio_i = 4'h0;
    logic [3:0] sio_o;
    logic       oe;

    int total = 0;
    int bad = 0;

    logic [7:0] mem_m [65536];
    logic [7:0] mode_m = 8'h40;
    logic [3:0] nb   [256];
    logic [3:0] rnib [256];
    logic       oe_pre, oe_first, oe_last, oe_after;

    idli_sqi_mem_m #(.ADDR_W(16)) dut (
        .i_mem_gck   (gck),
        .i_mem_rst_n (rst_n),
        .i_mem_sck   (sck),
        .i_mem_cs    (cs),
        .i_mem_sio   (sio_i),
        .o_mem_sio   (sio_o),
        .o_mem_sio_oe(oe)
    );

    always #5 gck = ~gck;

    // reference: address sequencing by mode
    function automatic logic [15:0] nxt(input logic [15:0] a, input logic [7:0] m);
        case (m[7:6])
            2'b00:   return a;
            2'b10:   return {a[15:5], a[4:0] + 5'd1};
            default: return a + 16'd1;
        endcase
    endfunction

    function automatic void model_write(input logic [15:0] a, input int nn);
        logic [15:0] p = a;
        for (int i = 0; i < nn / 2; i++) begin
            mem_m[p] = {nb[2*i], nb[2*i+1]};
            p = nxt(p, mode_m);
        end
    endfunction

    task automatic cyc(input logic [3:0] d, output logic [3:0] q);
        @(negedge gck); sck = 1'b1; sio_i = d;
        @(negedge gck); sck = 1'b0; q = sio_o;
    endtask

    task automatic cs_high();
        @(negedge gck); cs = 1'b1;
        @(negedge gck);
        @(negedge gck);
    endtask

    task automatic send_addr(input logic [15:0] a);
        logic [3:0] q;
        for (int i = 3; i >= 0; i--) cyc(a[4*i +: 4], q);
    endtask

    task automatic do_write(input logic [15:0] a, input int nn);
        logic [3:0] q;
        @(negedge gck); cs = 1'b0;
        cyc(4'h0, q); cyc(4'h2, q);
        send_addr(a);
        for (int i = 0; i < nn; i++) cyc(nb[i], q);
        cs_high();
    endtask

    task automatic do_read(input logic [15:0] a, input int nbytes, input bit same_edge);
        logic [3:0] q;
        if (same_edge) begin
            @(negedge gck); cs = 1'b0; sck = 1'b1; sio_i = 4'h0;
            @(negedge gck); sck = 1'b0;
        end else begin
            @(negedge gck); cs = 1'b0;
            cyc(4'h0, q);
        end
        cyc(4'h3, q);
        send_addr(a);
        cyc(4'h0, q); oe_pre = oe;
        cyc(4'h0, q); oe_first = oe; rnib[0] = q;
        for (int i = 1; i < 2 * nbytes; i++) begin
            cyc(4'h0, q);
            rnib[i] = q;
        end
        @(negedge gck); oe_last = oe; cs = 1'b1;
        @(negedge gck); oe_after = oe;
        @(negedge gck);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge gck);
        total++; if (sio_o !== 4'h0) begin bad++; $display("FAIL reset_sio: got %h want 0", sio_o); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe); end
        rst_n = 1'b1;
        repeat (2) @(negedge gck);
    endtask

    task automatic test_basic();
        logic [3:0] exp [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
        for (int i = 0; i < 4; i++) nb[i] = exp[i];
        do_write(16'h1234, 4); model_write(16'h1234, 4);
        do_read(16'h1234, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rnib[i] !== exp[i]) begin bad++; $display("FAIL basic_nib%0d: got %h want %h", i, rnib[i], exp[i]); end
        end
        total++; if (oe_pre !== 1'b0) begin bad++; $display("FAIL basic_oe_early: got %b want 0", oe_pre); end
        total++; if (oe_first !== 1'b1) begin bad++; $display("FAIL basic_oe_first: got %b want 1", oe_first); end
        total++; if (oe_last !== 1'b1) begin bad++; $display("FAIL basic_oe_hold: got %b want 1", oe_last); end
        total++; if (oe_after !== 1'b0) begin bad++; $display("FAIL basic_oe_fall: got %b want 0", oe_after); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        nb[0] = 4'h1; nb[1] = 4'h2; nb[2] = 4'h3; nb[3] = 4'h4;
        do_write(16'hFFFF, 4); model_write(16'hFFFF, 4);
        do_read(16'h0000, 1, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== 8'h34) begin bad++; $display("FAIL wrap_mem0: got %h want 34", b); end
        do_read(16'hFFFF, 2, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== 8'h12) begin bad++; $display("FAIL wrap_memFFFF: got %h want 12", b); end
        b = {rnib[2], rnib[3]};
        total++; if (b !== mem_m[16'h0000]) begin bad++; $display("FAIL wrap_read_next: got %h want %h", b, mem_m[16'h0000]); end
    endtask

    task automatic test_partial();
        logic [7:0] b;
        nb[0] = 4'h5; nb[1] = 4'hA;
        do_write(16'h0011, 2); model_write(16'h0011, 2);
        nb[0] = 4'h7; nb[1] = 4'hE; nb[2] = 4'h9;
        do_write(16'h0010, 3); model_write(16'h0010, 3);
        do_read(16'h0010, 2, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== 8'h7E) begin bad++; $display("FAIL partial_full: got %h want 7e", b); end
        b = {rnib[2], rnib[3]};
        total++; if (b !== mem_m[16'h0011]) begin bad++; $display("FAIL partial_lone: got %h want %h", b, mem_m[16'h0011]); end
    endtask

    task automatic try_ignored(input logic [7:0] ins, input string nm);
        logic [3:0] q;
        int seen = 0;
        @(negedge gck); cs = 1'b0;
        cyc(ins[7:4], q); cyc(ins[3:0], q);
        for (int i = 0; i < 8; i++) begin
            cyc(4'($urandom), q);
            if (oe !== 1'b0 || q !== 4'h0) seen++;
        end
        cs_high();
        total++; if (seen != 0) begin bad++; $display("FAIL ignore_%s: got %0d driven cycles want 0", nm, seen); end
    endtask

    task automatic test_ignore();
        logic [7:0] b;
        try_ignored(8'hFF, "ff");
`ifndef IDLI_SQI_MEM_MODE_EN
        try_ignored(8'h01, "wrmr");
        try_ignored(8'h05, "rdmr");
`endif
        do_read(16'h1234, 2, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== mem_m[16'h1234]) begin bad++; $display("FAIL ignore_after0: got %h want %h", b, mem_m[16'h1234]); end
        b = {rnib[2], rnib[3]};
        total++; if (b !== mem_m[16'h1235]) begin bad++; $display("FAIL ignore_after1: got %h want %h", b, mem_m[16'h1235]); end
    endtask

    task automatic test_cs_same_edge();
        logic [7:0] b;
        do_read(16'h1234, 1, 1'b1);
        b = {rnib[0], rnib[1]};
        total++; if (b !== mem_m[16'h1234]) begin bad++; $display("FAIL cs_same_edge: got %h want %h", b, mem_m[16'h1234]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [15:0] base = 16'($urandom);
            int n   = $urandom_range(1, 16);
            int off;
            int len;
            logic [15:0] p;
            for (int i = 0; i < 2 * n; i++) nb[i] = 4'($urandom);
            do_write(base, 2 * n); model_write(base, 2 * n);
            off = $urandom_range(0, n - 1);
            len = $urandom_range(1, n - off);
            p = base + 16'(off);
            do_read(p, len, 1'b0);
            for (int i = 0; i < len; i++) begin
                total++;
                if ({rnib[2*i], rnib[2*i+1]} !== mem_m[p]) begin
                    bad++;
                    $display("FAIL random_rd it%0d @%h: got %h want %h", it, p, {rnib[2*i], rnib[2*i+1]}, mem_m[p]);
                end
                p = nxt(p, mode_m);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] q;
        logic [7:0] b;
        nb[0] = 4'h6; nb[1] = 4'h9;
        do_write(16'h0040, 2); model_write(16'h0040, 2);
        @(negedge gck); cs = 1'b0;
        cyc(4'h0, q); cyc(4'h2, q);
        send_addr(16'h0040);
        cyc(4'hF, q);
        @(negedge gck); rst_n = 1'b0;
        @(negedge gck); rst_n = 1'b1;
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe: got %b want 0", oe); end
        total++; if (sio_o !== 4'h0) begin bad++; $display("FAIL rstmid_sio: got %h want 0", sio_o); end
        cyc(4'h0, q);
        cyc(4'h0, q);
        cs_high();
        do_read(16'h0040, 1, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== 8'h69) begin bad++; $display("FAIL rstmid_mem: got %h want 69", b); end
    endtask

`ifdef IDLI_SQI_MEM_MODE_EN
    task automatic wrmr(input logic [7:0] m);
        logic [3:0] q;
        @(negedge gck); cs = 1'b0;
        cyc(4'h0, q); cyc(4'h1, q); cyc(m[7:4], q); cyc(m[3:0], q);
        cyc(4'hF, q);
        cs_high();
        mode_m = m;
    endtask

    task automatic test_mode();
        logic [3:0] q0, q1, q2;
        logic [7:0] b;
        nb[0] = 4'hC; nb[1] = 4'h3; do_write(16'h001F, 2); model_write(16'h001F, 2);
        nb[0] = 4'h9; nb[1] = 4'h6; do_write(16'h0000, 2); model_write(16'h0000, 2);
        wrmr(8'h80);
        do_read(16'h001F, 2, 1'b0);
        b = {rnib[0], rnib[1]};
        total++; if (b !== mem_m[16'h001F]) begin bad++; $display("FAIL page_b0: got %h want %h", b, mem_m[16'h001F]); end
        b = {rnib[2], rnib[3]};
        total++; if (b !== mem_m[nxt(16'h001F, mode_m)]) begin bad++; $display("FAIL page_b1: got %h want %h", b, mem_m[16'h0000]); end
        @(negedge gck); cs = 1'b0;
        cyc(4'h0, q0); cyc(4'h5, q0); cyc(4'h0, q1); cyc(4'h0, q2);
        cs_high();
        total++; if ({q0, q1, q2} !== {mode_m[7:4], mode_m[3:0], mode_m[7:4]}) begin
            bad++; $display("FAIL rdmr: got %h%h%h want %h%h", q0, q1, q2, mode_m, mode_m[7:4]);
        end
        wrmr(8'h00);
        do_read(16'h1234, 2, 1'b0);
        b = {rnib[2], rnib[3]};
        total++; if (b !== mem_m[16'h1234]) begin bad++; $display("FAIL byte_mode: got %h want %h", b, mem_m[16'h1234]); end
        wrmr(8'h40);
    endtask
`endif

    initial begin
        fork
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_basic();
        test_wrap();
        test_partial();
        test_ignore();
        test_cs_same_edge();
        test_random();
        test_reset_mid();
`ifdef IDLI_SQI_MEM_MODE_EN
        test_mode();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
